// File: rtl/pixel_writeback.sv
// pixel_writeback
//   Write-side stage between the dehaze datapath and the result frame memory.
//   Accepted pixels are queued in a small skid FIFO and written to memory in
//   raster order (address 0 .. Image_width*Image_height-1), so the memory can
//   stall without losing data. A one-cycle `done` pulse marks the frame end.
//
//   Optional feature: define PIXEL_WB_CHECKSUM_EN to build a modulo-2^32 sum
//   of all written pixels on `checksum`; otherwise `checksum` is tied to 0.
//
// Ports
//   gen_clk    in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle pulse, arms a new frame (IDLE only)
//   pix_valid  in   upstream pixel valid
//   pix_data   in   upstream pixel {R,G,B}
//   pix_ready  out  pixel accepted this cycle when pix_valid is high
//   mem_stall  in   memory cannot take a write this cycle
//   we         out  frame memory write enable
//   waddr      out  frame memory write address
//   wdata      out  frame memory write data
//   line_done  out  pulse with the last write of each row
//   busy       out  frame in progress (RUN, DRAIN, DONE)
//   done       out  pulse the cycle after the final write
//   checksum   out  frame checksum (0 unless PIXEL_WB_CHECKSUM_EN)
module pixel_writeback #(
    parameter int Image_width  = 712,
    parameter int Image_height = 712,
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDR_W       = 19
) (
    input  logic              gen_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [23:0]       pix_data,
    output logic              pix_ready,
    input  logic              mem_stall,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [23:0]       wdata,
    output logic              line_done,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int COL_W = $clog2(Image_width + 1);

    // Frame counters carry one extra bit so the total itself is representable.
    localparam logic [ADDR_W:0]  TOTAL    = (ADDR_W+1)'(Image_width * Image_height);
    localparam logic [ADDR_W:0]  TOTAL_M1 = (ADDR_W+1)'(Image_width * Image_height - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(Image_width - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [ADDR_W:0]  acc_cnt;
    logic [ADDR_W:0]  wr_cnt;
    logic [COL_W-1:0] col;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic [23:0]      fifo_mem [FIFO_DEPTH];

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic [23:0] head;

    assign fifo_full  = (fifo_cnt == CNT_FULL);
    assign fifo_empty = (fifo_cnt == '0);
    assign head       = fifo_mem[rd_ptr];

    // Readiness depends only on registered state: a pop in the same cycle does
    // not open a slot for the incoming pixel.
    assign pix_ready = (state == RUN) && !fifo_full && (acc_cnt < TOTAL);
    assign push      = pix_valid && pix_ready;
    assign pop       = ((state == RUN) || (state == DRAIN)) && !fifo_empty && !mem_stall;
    assign busy      = (state != IDLE);

    // FIFO storage holds data only; validity is tracked by the pointers.
    always_ff @(posedge gen_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= pix_data;
        end
    end

    always_ff @(posedge gen_clk) begin
        if (rst) begin
            state     <= IDLE;
            acc_cnt   <= '0;
            wr_cnt    <= '0;
            col       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fifo_cnt  <= '0;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= 24'h000000;
            line_done <= 1'b0;
            done      <= 1'b0;
        end else begin
            we        <= 1'b0;
            line_done <= 1'b0;
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        acc_cnt  <= '0;
                        wr_cnt   <= '0;
                        col      <= '0;
                        rd_ptr   <= '0;
                        wr_ptr   <= '0;
                        fifo_cnt <= '0;
                        waddr    <= '0;
                    end
                end
                RUN: begin
                    if (push && (acc_cnt == TOTAL_M1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // wr_cnt reaches the total on the edge that issued the
                    // final write, so `done` lands one cycle after that `we`.
                    if (wr_cnt == TOTAL) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // push/pop only happen in RUN/DRAIN, never alongside the IDLE clear
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                acc_cnt <= acc_cnt + 1'b1;
            end

            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                we        <= 1'b1;
                wdata     <= head;
                waddr     <= wr_cnt[ADDR_W-1:0];
                wr_cnt    <= wr_cnt + 1'b1;
                line_done <= (col == COL_LAST);
                col       <= (col == COL_LAST) ? '0 : col + 1'b1;
            end

            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

`ifdef PIXEL_WB_CHECKSUM_EN
    logic [31:0] csum;

    // Cleared on start, accumulates each write, and naturally holds after
    // the frame because no pops occur outside RUN/DRAIN.
    always_ff @(posedge gen_clk) begin
        if (rst) begin
            csum <= '0;
        end else if ((state == IDLE) && start) begin
            csum <= '0;
        end else if (pop) begin
            csum <= csum + {8'd0, head};
        end
    end

    assign checksum = csum;
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_pixel_writeback.sv
module tb_pixel_writeback;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int AW = 4;

`ifdef PIXEL_WB_CHECKSUM_EN
    localparam logic [31:0] EXP_SUM = 32'd78;
`else
    localparam logic [31:0] EXP_SUM = 32'd0;
`endif

    logic          gen_clk;
    logic          rst;
    logic          start;
    logic          pix_valid;
    logic [23:0]   pix_data;
    logic          pix_ready;
    logic          mem_stall;
    logic          we;
    logic [AW-1:0] waddr;
    logic [23:0]   wdata;
    logic          line_done;
    logic          busy;
    logic          done;
    logic [31:0]   checksum;

    pixel_writeback #(
        .Image_width (W),
        .Image_height(H),
        .FIFO_DEPTH  (4),
        .ADDR_W      (AW)
    ) dut (
        .gen_clk  (gen_clk),
        .rst      (rst),
        .start    (start),
        .pix_valid(pix_valid),
        .pix_data (pix_data),
        .pix_ready(pix_ready),
        .mem_stall(mem_stall),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .line_done(line_done),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    initial gen_clk = 1'b0;
    always #5 gen_clk = ~gen_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge gen_clk) cyc <= cyc + 1;

    // write log filled by the monitor
    logic [AW-1:0] log_addr [32];
    logic [23:0]   log_data [32];
    logic          log_ld   [32];
    int wr_n, done_n, done_cyc, first_we_cyc, last_we_cyc;
    int we_after_done, bad_we_stall, stray_ld;
    logic busy_at_done;
    logic prev_stall = 1'b0;

    // driver results
    int accepted, first_acc_cyc, last_acc_cyc;
    bit ready_low_seen;

    always @(negedge gen_clk) begin
        if (we) begin
            if (wr_n < 32) begin
                log_addr[wr_n] = waddr;
                log_data[wr_n] = wdata;
                log_ld[wr_n]   = line_done;
            end
            if (done_n > 0) we_after_done++;
            if (prev_stall) bad_we_stall++;
            if (wr_n == 0) first_we_cyc = cyc;
            last_we_cyc = cyc;
            wr_n++;
        end
        if (line_done && !we) stray_ld++;
        if (done) begin
            done_n++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
        prev_stall = mem_stall;
    end

    task automatic clear_log();
        wr_n = 0; done_n = 0; done_cyc = -1; first_we_cyc = -1; last_we_cyc = -1;
        we_after_done = 0; bad_we_stall = 0; stray_ld = 0; busy_at_done = 1'b0;
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(posedge gen_clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_frame(input int npix, input int limit, input int stall_at,
                               input int stall_len, input int start_at, input int brk_writes);
        int next, guard, stall_left;
        bit stall_used, start_used, rdy;
        next = 1; guard = 0; stall_left = 0; stall_used = 0; start_used = 0;
        accepted = 0; ready_low_seen = 0; first_acc_cyc = -1; last_acc_cyc = -1;
        while (accepted < npix && guard < limit) begin
            if (brk_writes > 0 && wr_n >= brk_writes) break;
            if (!stall_used && stall_at >= 0 && accepted == stall_at) begin
                stall_left = stall_len;
                stall_used = 1;
            end
            mem_stall = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            start = (!start_used && start_at >= 0 && accepted == start_at);
            if (start) start_used = 1;
            pix_valid = 1'b1;
            pix_data  = 24'(next);
            @(negedge gen_clk);
            rdy = pix_ready;
            @(posedge gen_clk); #1;
            if (rdy) begin
                if (accepted == 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                accepted++;
                next++;
            end else begin
                ready_low_seen = 1;
            end
            guard++;
        end
        pix_valid = 1'b0;
        start     = 1'b0;
        mem_stall = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int g;
        g = 0;
        while (done_n == 0 && g < limit) begin
            @(posedge gen_clk); #1;
            g++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge gen_clk);
        #1;
        total++; if (we !== 1'b0)        begin bad++; $display("FAIL reset_we got=%b exp=0", we); end
        total++; if (line_done !== 1'b0) begin bad++; $display("FAIL reset_line_done got=%b exp=0", line_done); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL reset_pix_ready got=%b exp=0", pix_ready); end
        total++; if (waddr !== '0)       begin bad++; $display("FAIL reset_waddr got=%0d exp=0", waddr); end
        total++; if (wdata !== 24'h0)    begin bad++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
        total++; if (checksum !== 32'd0) begin bad++; $display("FAIL reset_checksum got=%0d exp=0", checksum); end
        rst = 1'b0;
        @(posedge gen_clk); #1;
        total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL idle_pix_ready got=%b exp=0", pix_ready); end
    endtask

    task automatic test_basic();
        clear_log();
        start_frame();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_run got=%b exp=1", busy); end
        drive_frame(N, 60, -1, 0, -1, 0);
        wait_done(40);
        total++; if (done_n !== 1) begin bad++; $display("FAIL basic_done_seen got=%0d exp=1", done_n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after_done got=%b exp=0", busy); end
        total++; if (accepted !== N) begin bad++; $display("FAIL basic_accepted got=%0d exp=%0d", accepted, N); end
        total++; if (ready_low_seen !== 1'b0) begin bad++; $display("FAIL basic_ready_gap got=%b exp=0", ready_low_seen); end
        total++; if (last_acc_cyc - first_acc_cyc !== N - 1) begin bad++; $display("FAIL basic_throughput got=%0d exp=%0d", last_acc_cyc - first_acc_cyc, N - 1); end
        total++; if (first_we_cyc !== first_acc_cyc + 1) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", first_we_cyc, first_acc_cyc + 1); end
        total++; if (wr_n !== N) begin bad++; $display("FAIL basic_writes got=%0d exp=%0d", wr_n, N); end
        for (int i = 0; i < N; i++) begin
            total++;
            if (log_addr[i] !== AW'(i) || log_data[i] !== 24'(i + 1) || log_ld[i] !== ((i % W) == W - 1)) begin
                bad++;
                $display("FAIL basic_write[%0d] got addr=%0d data=%h ld=%b exp addr=%0d data=%h ld=%b",
                         i, log_addr[i], log_data[i], log_ld[i], i, i + 1, (i % W) == W - 1);
            end
        end
        total++; if (done_cyc !== last_we_cyc + 1) begin bad++; $display("FAIL basic_done_timing got=%0d exp=%0d", done_cyc, last_we_cyc + 1); end
        total++; if (busy_at_done !== 1'b1) begin bad++; $display("FAIL basic_busy_at_done got=%b exp=1", busy_at_done); end
        total++; if (checksum !== EXP_SUM) begin bad++; $display("FAIL basic_checksum got=%0d exp=%0d", checksum, EXP_SUM); end
        repeat (4) @(posedge gen_clk);
        #1;
        total++; if (checksum !== EXP_SUM) begin bad++; $display("FAIL basic_checksum_hold got=%0d exp=%0d", checksum, EXP_SUM); end
        total++; if (done_n !== 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", done_n); end
        total++; if (stray_ld !== 0) begin bad++; $display("FAIL basic_stray_line_done got=%0d exp=0", stray_ld); end
    endtask

    task automatic test_backpressure();
        clear_log();
        start_frame();
        drive_frame(N, 80, 2, 6, -1, 0);
        wait_done(40);
        total++; if (ready_low_seen !== 1'b1) begin bad++; $display("FAIL bp_ready_drop got=%b exp=1", ready_low_seen); end
        total++; if (bad_we_stall !== 0) begin bad++; $display("FAIL bp_we_during_stall got=%0d exp=0", bad_we_stall); end
        total++; if (accepted !== N) begin bad++; $display("FAIL bp_accepted got=%0d exp=%0d", accepted, N); end
        total++; if (wr_n !== N) begin bad++; $display("FAIL bp_writes got=%0d exp=%0d", wr_n, N); end
        for (int i = 0; i < N; i++) begin
            total++;
            if (log_addr[i] !== AW'(i) || log_data[i] !== 24'(i + 1)) begin
                bad++;
                $display("FAIL bp_write[%0d] got addr=%0d data=%h exp addr=%0d data=%h",
                         i, log_addr[i], log_data[i], i, i + 1);
            end
        end
        total++; if (done_n !== 1) begin bad++; $display("FAIL bp_done got=%0d exp=1", done_n); end
        total++; if (checksum !== EXP_SUM) begin bad++; $display("FAIL bp_checksum got=%0d exp=%0d", checksum, EXP_SUM); end
    endtask

    task automatic test_overrun();
        clear_log();
        start_frame();
        drive_frame(N + 3, 40, -1, 0, -1, 0);
        wait_done(40);
        repeat (5) @(posedge gen_clk);
        #1;
        total++; if (accepted !== N) begin bad++; $display("FAIL ovr_accepted got=%0d exp=%0d", accepted, N); end
        total++; if (wr_n !== N) begin bad++; $display("FAIL ovr_writes got=%0d exp=%0d", wr_n, N); end
        total++; if (we_after_done !== 0) begin bad++; $display("FAIL ovr_we_after_done got=%0d exp=0", we_after_done); end
        total++; if (done_n !== 1) begin bad++; $display("FAIL ovr_done got=%0d exp=1", done_n); end
        total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL ovr_pix_ready got=%b exp=0", pix_ready); end
    endtask

    task automatic test_reset_mid();
        clear_log();
        start_frame();
        drive_frame(N, 60, -1, 0, -1, 5);
        rst = 1'b1;
        @(posedge gen_clk); #1;
        total++; if (we !== 1'b0)        begin bad++; $display("FAIL rmid_we got=%b exp=0", we); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        total++; if (waddr !== '0)       begin bad++; $display("FAIL rmid_waddr got=%0d exp=0", waddr); end
        total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL rmid_pix_ready got=%b exp=0", pix_ready); end
        rst = 1'b0;
        clear_log();
        repeat (3) @(posedge gen_clk);
        #1;
        total++; if (wr_n !== 0) begin bad++; $display("FAIL rmid_no_write got=%0d exp=0", wr_n); end
        start_frame();
        drive_frame(N, 60, -1, 0, -1, 0);
        wait_done(40);
        total++; if (wr_n !== N) begin bad++; $display("FAIL rmid_writes got=%0d exp=%0d", wr_n, N); end
        for (int i = 0; i < N; i++) begin
            total++;
            if (log_addr[i] !== AW'(i) || log_data[i] !== 24'(i + 1)) begin
                bad++;
                $display("FAIL rmid_write[%0d] got addr=%0d data=%h exp addr=%0d data=%h",
                         i, log_addr[i], log_data[i], i, i + 1);
            end
        end
        total++; if (done_n !== 1) begin bad++; $display("FAIL rmid_done got=%0d exp=1", done_n); end
        total++; if (checksum !== EXP_SUM) begin bad++; $display("FAIL rmid_checksum got=%0d exp=%0d", checksum, EXP_SUM); end
    endtask

    task automatic test_ignored_start();
        clear_log();
        start_frame();
        drive_frame(N, 60, -1, 0, 5, 0);
        wait_done(40);
        total++; if (accepted !== N) begin bad++; $display("FAIL istart_accepted got=%0d exp=%0d", accepted, N); end
        total++; if (wr_n !== N) begin bad++; $display("FAIL istart_writes got=%0d exp=%0d", wr_n, N); end
        for (int i = 0; i < N; i++) begin
            total++;
            if (log_addr[i] !== AW'(i) || log_data[i] !== 24'(i + 1)) begin
                bad++;
                $display("FAIL istart_write[%0d] got addr=%0d data=%h exp addr=%0d data=%h",
                         i, log_addr[i], log_data[i], i, i + 1);
            end
        end
        total++; if (done_n !== 1) begin bad++; $display("FAIL istart_done got=%0d exp=1", done_n); end
        total++; if (checksum !== EXP_SUM) begin bad++; $display("FAIL istart_checksum got=%0d exp=%0d", checksum, EXP_SUM); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0; mem_stall = 1'b0;
        clear_log();
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_reset_mid();
        test_ignored_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
